// File: rtl/lvds_p2s_framer.sv
// Downlink LVDS framer: buffers payload bytes and lengths, then emits sync/len/payload[/CRC-16] frames MSB first.
// Define LVDS_FRAMER_CRC_EN to include the CRC-16/CCITT-FALSE trailer field.
module lvds_p2s_framer #(
    parameter int          DEPTH     = 4096,
    parameter int          LQ_DEPTH  = 4,
    parameter logic [15:0] SYNC_WORD = 16'hEB90,
    parameter int          GAP_BITS  = 16
) (
    input  logic        clk100m,
    input  logic        rst_n_100m,
    input  logic        i_p2s_rstn,
    input  logic        i_len_vld,
    input  logic [15:0] i_data_len,
    input  logic        i_data_vld,
    input  logic [7:0]  i_data,
    output logic        o_ser_data,
    output logic        o_ser_vld,
    output logic        o_frame_start,
    output logic        o_busy,
    output logic        o_ovf,
    output logic        o_len_err
);

    localparam int          AW      = $clog2(DEPTH);
    localparam int          LAW     = $clog2(LQ_DEPTH);
    localparam logic [16:0] MAX_LEN = 17'(DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_LEN, S_PAY, S_CRC, S_GAP} state_t;

    logic [7:0]     r_mem [DEPTH];
    logic [AW-1:0]  r_wrPtr, r_rdPtr;
    logic [AW:0]    r_pCnt;
    logic [15:0]    r_lq [LQ_DEPTH];
    logic [LAW-1:0] r_lqWr, r_lqRd;
    logic [LAW:0]   r_lqCnt;

    state_t      r_state, w_next;
    logic [15:0] r_cnt, r_len, r_byteLeft;
    logic [7:0]  r_byte;
    logic        r_serData, r_serVld, r_frameStart, r_ovf, r_lenErr;

    logic        w_pFull, w_pPush, w_pPop, w_lenOk, w_lqFull, w_lqPush, w_ready;
    logic        w_enterSync, w_bit, w_vld;
    logic [15:0] w_lHead;

`ifdef LVDS_FRAMER_CRC_EN
    logic [15:0] r_crc;

    function automatic logic [15:0] crcByte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] v;
        v = c ^ {d, 8'h00};
        for (int i = 0; i < 8; i++)
            v = v[15] ? ({v[14:0], 1'b0} ^ 16'h1021) : {v[14:0], 1'b0};
        return v;
    endfunction
`endif

    assign w_pFull  = (r_pCnt == (AW+1)'(DEPTH));
    assign w_pPush  = i_data_vld && !w_pFull;
    assign w_lenOk  = (i_data_len != 16'd0) && ({1'b0, i_data_len} <= MAX_LEN);
    assign w_lqFull = (r_lqCnt == (LAW+1)'(LQ_DEPTH));
    assign w_lqPush = i_len_vld && w_lenOk && !w_lqFull;
    assign w_lHead  = r_lq[r_lqRd];
    assign w_ready  = (r_lqCnt != '0) && (17'(r_pCnt) >= {1'b0, w_lHead});

    // Storage arrays carry no reset so they can map onto block RAM.
    always_ff @(posedge clk100m) begin
        if (i_p2s_rstn && w_pPush)
            r_mem[r_wrPtr] <= i_data;
        if (i_p2s_rstn && w_lqPush)
            r_lq[r_lqWr] <= i_data_len;
    end

    always_ff @(posedge clk100m or negedge rst_n_100m) begin
        if (!rst_n_100m) begin
            r_wrPtr  <= '0;
            r_rdPtr  <= '0;
            r_pCnt   <= '0;
            r_lqWr   <= '0;
            r_lqRd   <= '0;
            r_lqCnt  <= '0;
            r_ovf    <= 1'b0;
            r_lenErr <= 1'b0;
        end else if (!i_p2s_rstn) begin
            r_wrPtr  <= '0;
            r_rdPtr  <= '0;
            r_pCnt   <= '0;
            r_lqWr   <= '0;
            r_lqRd   <= '0;
            r_lqCnt  <= '0;
            r_ovf    <= 1'b0;
            r_lenErr <= 1'b0;
        end else begin
            if (w_pPush) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_pPop)  r_rdPtr <= r_rdPtr + 1'b1;
            r_pCnt <= r_pCnt + (AW+1)'(w_pPush) - (AW+1)'(w_pPop);
            if (w_lqPush)    r_lqWr <= r_lqWr + 1'b1;
            if (w_enterSync) r_lqRd <= r_lqRd + 1'b1;
            r_lqCnt  <= r_lqCnt + (LAW+1)'(w_lqPush) - (LAW+1)'(w_enterSync);
            if (i_data_vld && w_pFull) r_ovf <= 1'b1;
            r_lenErr <= i_len_vld && !w_lqPush;
        end
    end

    // Field bit index counts up; ~cnt picks bits MSB first.
    always_comb begin
        w_next      = r_state;
        w_enterSync = 1'b0;
        w_pPop      = 1'b0;
        w_bit       = 1'b0;
        w_vld       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_ready) begin
                    w_next      = S_SYNC;
                    w_enterSync = 1'b1;
                end
            end
            S_SYNC: begin
                w_vld = 1'b1;
                w_bit = SYNC_WORD[~r_cnt[3:0]];
                if (r_cnt[3:0] == 4'hF) w_next = S_LEN;
            end
            S_LEN: begin
                w_vld = 1'b1;
                w_bit = r_len[~r_cnt[3:0]];
                if (r_cnt[3:0] == 4'hF) begin
                    w_next = S_PAY;
                    w_pPop = 1'b1;
                end
            end
            S_PAY: begin
                w_vld = 1'b1;
                w_bit = r_byte[~r_cnt[2:0]];
                if (r_cnt[2:0] == 3'd7) begin
                    if (r_byteLeft == 16'd1)
`ifdef LVDS_FRAMER_CRC_EN
                        w_next = S_CRC;
`else
                        w_next = S_GAP;
`endif
                    else
                        w_pPop = 1'b1;
                end
            end
`ifdef LVDS_FRAMER_CRC_EN
            S_CRC: begin
                w_vld = 1'b1;
                w_bit = r_crc[~r_cnt[3:0]];
                if (r_cnt[3:0] == 4'hF) w_next = S_GAP;
            end
`endif
            S_GAP: begin
                if (r_cnt == 16'(GAP_BITS - 1)) begin
                    if (w_ready) begin
                        w_next      = S_SYNC;
                        w_enterSync = 1'b1;
                    end else begin
                        w_next = S_IDLE;
                    end
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Serial outputs are registered, so they trail the FSM by one cycle.
    always_ff @(posedge clk100m or negedge rst_n_100m) begin
        if (!rst_n_100m) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_len        <= '0;
            r_byteLeft   <= '0;
            r_byte       <= '0;
            r_serData    <= 1'b0;
            r_serVld     <= 1'b0;
            r_frameStart <= 1'b0;
        end else if (!i_p2s_rstn) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_serData    <= 1'b0;
            r_serVld     <= 1'b0;
            r_frameStart <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_cnt <= '0;
            else if (r_state != S_IDLE)
                r_cnt <= r_cnt + 16'd1;
            if (w_enterSync)
                r_len <= w_lHead;
            if (r_state == S_LEN && w_next == S_PAY)
                r_byteLeft <= r_len;
            else if (r_state == S_PAY && r_cnt[2:0] == 3'd7)
                r_byteLeft <= r_byteLeft - 16'd1;
            if (w_pPop)
                r_byte <= r_mem[r_rdPtr];
            r_serVld     <= w_vld;
            r_serData    <= w_vld & w_bit;
            r_frameStart <= (r_state == S_SYNC) && (r_cnt == 16'd0);
        end
    end

`ifdef LVDS_FRAMER_CRC_EN
    always_ff @(posedge clk100m or negedge rst_n_100m) begin
        if (!rst_n_100m)
            r_crc <= 16'hFFFF;
        else if (w_enterSync)
            r_crc <= 16'hFFFF;
        else if (w_pPop && i_p2s_rstn)
            r_crc <= crcByte(r_crc, r_mem[r_rdPtr]);
    end
`endif

    assign o_ser_data    = r_serData;
    assign o_ser_vld     = r_serVld;
    assign o_frame_start = r_frameStart;
    assign o_busy        = (r_state != S_IDLE);
    assign o_ovf         = r_ovf;
    assign o_len_err     = r_lenErr;

endmodule
